// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential multiplier (start/done handshake) among NUM_REQ
//   clients using round-robin arbitration. The winner's operands are latched,
//   the multiplier is started with a one-cycle pulse, and its product is
//   returned to the winner with a one-cycle ack. All outputs are registered.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles without m_done (result forced to 0, ack + err pulse).
// Without the macro WAIT lasts until m_done and err is tied low.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      in   [NUM_REQ]        request per client, held until its ack
//   a_in     in   [NUM_REQ*DATA_W] operand A, client i at [i*DATA_W +: DATA_W]
//   b_in     in   [NUM_REQ*DATA_W] operand B, same packing
//   gnt      out  [NUM_REQ]        one-hot owner of the multiplier
//   ack      out  [NUM_REQ]        one-cycle result-valid pulse per client
//   result   out  [2*DATA_W]       product, valid with ack, held afterwards
//   err      out  one-cycle pulse alongside ack on timeout
//   busy     out  high whenever the FSM is not idle
//   m_start  out  one-cycle start pulse to the multiplier
//   m_a/m_b  out  [DATA_W]         latched operands to the multiplier
//   m_done   in   multiplier done, only honoured while waiting
//   m_data   in   [2*DATA_W]       multiplier product, valid with m_done
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] a_in,
  input  logic [NUM_REQ*DATA_W-1:0] b_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [2*DATA_W-1:0]       result,
  output logic                      err,
  output logic                      busy,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_a,
  output logic [DATA_W-1:0]         m_b,
  input  logic                      m_done,
  input  logic [2*DATA_W-1:0]       m_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("mult_share_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic             tmo_hit;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Operand mux written as a constant-slice loop rather than a variable
  // part-select so the packing stays explicit.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == win_idx) begin
        win_a = a_in[k*DATA_W +: DATA_W];
        win_b = b_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // The client just served becomes lowest priority for the next round.
  assign ptr_inc = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (m_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= '0;
      ack     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      m_start <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      ptr     <= '0;
      idx     <= '0;
    end else begin
      ack     <= '0;
      m_start <= 1'b0;
      busy    <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (win_found) begin
            idx     <= win_idx;
            gnt     <= NUM_REQ'(1) << win_idx;
            m_a     <= win_a;
            m_b     <= win_b;
            m_start <= 1'b1;
          end
        end
        S_WAIT: begin
          // gnt is the one-hot of idx, so it doubles as the ack pattern.
          if (m_done) begin
            result <= m_data;
            ack    <= gnt;
          end else if (tmo_hit) begin
            result <= '0;
            ack    <= gnt;
          end
        end
        S_RESP: begin
          gnt <= '0;
          ptr <= ptr_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Hit on the TIMEOUT_CYC-th WAIT cycle; the counter restarts in START so
  // every WAIT entry begins from zero.
  assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == S_WAIT) && !m_done && tmo_hit;
      if (state == S_START)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
